vga_sync_porch: RTL and testbench
=================================

VGA_SYNC_PORCH -- requirements
Module: vga_sync_porch

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  TOTAL_COLS, 800, pixels per line incl. blanking
  TOTAL_ROWS, 525, lines per frame incl. blanking
  ACTIVE_COLS, 640, visible pixels per line
  ACTIVE_ROWS, 480, visible lines per frame
  H_FRONT_PORCH, 16, pixels between active end and hsync pulse
  H_BACK_PORCH, 48, pixels between hsync pulse end and line end
  V_FRONT_PORCH, 10, lines between active end and vsync pulse
  V_BACK_PORCH, 33, lines between vsync pulse end and frame end
  VIDEO_WIDTH, 4, bits per colour channel
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clock  input  1  pixel clock (25 MHz), sole clock
  reset  input  1  synchronous, active-high
  in_Hsync  input  1  active-area flag from sync generator, high = active columns
  in_Vsync  input  1  active-area flag from sync generator, high = active rows
  in_Red / in_Green / in_Blue  input  VIDEO_WIDTH each  pixel colour for the current input position
  out_Hsync  output  1  VGA hsync, active-low
  out_Vsync  output  1  VGA vsync, active-low
  out_Red / out_Green / out_Blue  output  VIDEO_WIDTH each  blanked, aligned colour
  out_locked  output  1  high once frame alignment acquired
  out_resync  output  1  one-cycle pulse on realignment while locked
REQ-003 One clock domain; reset SHALL be synchronous, active-high, sampled on posedge clock.

Function
REQ-004 Frame-start event (FSE) in cycle t SHALL be: in_Vsync=1, in_Vsync at t-1 = 0, and in_Hsync=1.
REQ-005 Internal col (10 bit) and row (10 bit) counters SHALL track the position of the input sample of the current cycle; col increments every cycle, wraps TOTAL_COLS-1 -> 0 with row increment; row wraps TOTAL_ROWS-1 -> 0.
REQ-006 On FSE, effective position for that cycle SHALL be (0,0) regardless of counter contents, and counters SHALL load col=1, row=0 for the next cycle.
REQ-007 FSE coinciding with counter wrap (counters already at (0,0)) SHALL behave identically to a normal increment; no resync.
REQ-008 States: UNLOCKED (after reset) -> LOCKED on first FSE; LOCKED persists until reset.
REQ-009 FSE in LOCKED with counters not at (0,0) SHALL realign per REQ-006 and assert out_resync for exactly the following cycle.
REQ-010 All outputs SHALL be registered; latency 1 cycle: outputs at t+1 reflect effective position and colour inputs of cycle t.
REQ-011 out_Hsync SHALL be 0 when col in [ACTIVE_COLS+H_FRONT_PORCH, TOTAL_COLS-H_BACK_PORCH-1] (defaults 656..751), else 1.
REQ-012 out_Vsync SHALL be 0 when row in [ACTIVE_ROWS+V_FRONT_PORCH, TOTAL_ROWS-V_BACK_PORCH-1] (defaults 490..491), else 1.
REQ-013 Colour outputs SHALL equal delayed inputs when col<ACTIVE_COLS and row<ACTIVE_ROWS, else 0.
REQ-014 In UNLOCKED: out_Hsync=1, out_Vsync=1, colours 0, out_locked=0, out_resync=0; FSE cycle itself SHALL produce locked outputs at t+1.
REQ-015 Comparisons SHALL be unsigned 10 bit; parameters SHALL satisfy ACTIVE+FP+BP < TOTAL per axis.

Reset
REQ-016 Reset SHALL force col=0, row=0, UNLOCKED, previous-in_Vsync register=0, and on the next cycle out_Hsync=1, out_Vsync=1, colours 0, out_locked=0, out_resync=0.
REQ-017 Reset asserted mid-frame SHALL discard alignment; re-lock requires a new FSE after reset deasserts.
REQ-018 Reset takes priority over FSE in the same cycle.

Verification
REQ-019 Reset, drive in_Vsync=0 for 100 cycles -> out_locked=0, syncs=1, colours 0 throughout.
REQ-020 FSE at t with RGB=F/A/5 -> at t+1 out_locked=1, out_Red/Green/Blue=F/A/5, syncs=1; at col 656 of row 0 out_Hsync falls, rises at col 752 (96 cycles low).
REQ-021 Free-run two frames from aligned upstream -> out_Vsync low for exactly 2 x 800 cycles per frame at rows 490-491; out_resync never asserts; colours 0 at col 640..799 and rows 480..524.
REQ-022 While locked, inject FSE at internal (col 300,row 100) -> out_resync high one cycle at t+1, following pixel output position = (1,0), out_locked stays 1.
REQ-023 Assert reset at row 200 col 400 for 1 cycle -> next cycle all outputs at reset values; no sync pulses until new FSE.

Source files
------------

// File: rtl/vga_sync_porch.sv
// vga_sync_porch
//   Turns the active-area flags of an upstream sync generator into VGA
//   timing. A local col/row counter pair follows the input stream. It is
//   re-aligned on every frame-start event: the rising edge of in_Vsync
//   while in_Hsync is high. From that position the block generates the
//   active-low hsync and vsync pulses and blanks the colour outside the
//   visible area. Every output is registered, so outputs lag the inputs by
//   one pixel clock.
//
// Ports
//   clock                          pixel clock, sole clock
//   reset                          synchronous, active-high
//   in_Hsync / in_Vsync            upstream active-column / active-row flags
//   in_Red / in_Green / in_Blue    colour for the current input position
//   out_Hsync / out_Vsync          VGA syncs, active-low
//   out_Red / out_Green / out_Blue blanked colour, one cycle behind the inputs
//   out_locked                     high once a frame start has been seen
//   out_resync                     one-cycle pulse when a locked frame start
//                                  lands away from the counter origin
module vga_sync_porch #(
  parameter int TOTAL_COLS    = 800,
  parameter int TOTAL_ROWS    = 525,
  parameter int ACTIVE_COLS   = 640,
  parameter int ACTIVE_ROWS   = 480,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_BACK_PORCH  = 48,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_BACK_PORCH  = 33,
  parameter int VIDEO_WIDTH   = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_Hsync,
  input  logic                   in_Vsync,
  input  logic [VIDEO_WIDTH-1:0] in_Red,
  input  logic [VIDEO_WIDTH-1:0] in_Green,
  input  logic [VIDEO_WIDTH-1:0] in_Blue,
  output logic                   out_Hsync,
  output logic                   out_Vsync,
  output logic [VIDEO_WIDTH-1:0] out_Red,
  output logic [VIDEO_WIDTH-1:0] out_Green,
  output logic [VIDEO_WIDTH-1:0] out_Blue,
  output logic                   out_locked,
  output logic                   out_resync
);

  // All position arithmetic is unsigned 10 bit.
  localparam logic [9:0] COL_LAST = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] ROW_LAST = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0] COL_ACT  = 10'(ACTIVE_COLS);
  localparam logic [9:0] ROW_ACT  = 10'(ACTIVE_ROWS);
  localparam logic [9:0] HS_FIRST = 10'(ACTIVE_COLS + H_FRONT_PORCH);
  localparam logic [9:0] HS_LAST  = 10'(TOTAL_COLS - H_BACK_PORCH - 1);
  localparam logic [9:0] VS_FIRST = 10'(ACTIVE_ROWS + V_FRONT_PORCH);
  localparam logic [9:0] VS_LAST  = 10'(TOTAL_ROWS - V_BACK_PORCH - 1);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  typedef struct packed {
    logic                   hsync;
    logic                   vsync;
    logic [VIDEO_WIDTH-1:0] red;
    logic [VIDEO_WIDTH-1:0] green;
    logic [VIDEO_WIDTH-1:0] blue;
    logic                   locked;
    logic                   resync;
  } pix_t;

  state_t     state, state_nxt;
  logic [9:0] col, row, col_nxt, row_nxt;
  logic [9:0] ecol, erow;
  logic       vs_prev;
  logic       fse;
  logic       at_origin;
  pix_t       pix_d, pix_q;

  always_comb begin
    fse       = in_Vsync & ~vs_prev & in_Hsync;
    at_origin = (col == 10'd0) && (row == 10'd0);

    // A frame start forces this cycle to (0,0). Advancing from the forced
    // position gives (1,0) next. A frame start that lands on the natural
    // wrap therefore behaves the same as a plain increment.
    ecol = fse ? 10'd0 : col;
    erow = fse ? 10'd0 : row;

    col_nxt = ecol + 10'd1;
    row_nxt = erow;
    if (ecol == COL_LAST) begin
      col_nxt = 10'd0;
      row_nxt = (erow == ROW_LAST) ? 10'd0 : erow + 10'd1;
    end

    state_nxt = state;
    if (fse) state_nxt = LOCKED;

    pix_d        = '0;
    pix_d.hsync  = 1'b1;
    pix_d.vsync  = 1'b1;
    // The frame-start cycle itself already drives locked outputs.
    if (state == LOCKED || fse) begin
      pix_d.locked = 1'b1;
      pix_d.hsync  = !(ecol >= HS_FIRST && ecol <= HS_LAST);
      pix_d.vsync  = !(erow >= VS_FIRST && erow <= VS_LAST);
      if (ecol < COL_ACT && erow < ROW_ACT) begin
        pix_d.red   = in_Red;
        pix_d.green = in_Green;
        pix_d.blue  = in_Blue;
      end
      pix_d.resync = (state == LOCKED) && fse && !at_origin;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= UNLOCKED;
      col          <= 10'd0;
      row          <= 10'd0;
      vs_prev      <= 1'b0;
      pix_q        <= '0;
      pix_q.hsync  <= 1'b1;
      pix_q.vsync  <= 1'b1;
    end else begin
      state   <= state_nxt;
      col     <= col_nxt;
      row     <= row_nxt;
      vs_prev <= in_Vsync;
      pix_q   <= pix_d;
    end
  end

  assign out_Hsync  = pix_q.hsync;
  assign out_Vsync  = pix_q.vsync;
  assign out_Red    = pix_q.red;
  assign out_Green  = pix_q.green;
  assign out_Blue   = pix_q.blue;
  assign out_locked = pix_q.locked;
  assign out_resync = pix_q.resync;

endmodule

// File: tb/tb_vga_sync_porch.sv
// Bench for vga_sync_porch. It has two instances that share the inputs.
// dut_d uses the default 640x480 timing and covers the line-level checks.
// dut_s uses a shrunken 20x15 raster: active 12x8, hsync at cols 14..16,
// vsync at rows 10..11. It covers the multi-frame cases in a few hundred
// cycles.
module tb_vga_sync_porch;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_hs, in_vs;
  logic [3:0] in_r, in_g, in_b;

  logic       d_hs, d_vs, d_lk, d_rs;
  logic [3:0] d_r, d_g, d_b;
  logic       s_hs, s_vs, s_lk, s_rs;
  logic [3:0] s_r, s_g, s_b;

  int checks = 0;
  int errors = 0;

  localparam logic [15:0] IDLE = 16'hC000;

  always #5 clock = ~clock;

  vga_sync_porch dut_d (
    .clock(clock), .reset(reset), .in_Hsync(in_hs), .in_Vsync(in_vs),
    .in_Red(in_r), .in_Green(in_g), .in_Blue(in_b),
    .out_Hsync(d_hs), .out_Vsync(d_vs), .out_Red(d_r), .out_Green(d_g),
    .out_Blue(d_b), .out_locked(d_lk), .out_resync(d_rs));

  vga_sync_porch #(
    .TOTAL_COLS(20), .TOTAL_ROWS(15), .ACTIVE_COLS(12), .ACTIVE_ROWS(8),
    .H_FRONT_PORCH(2), .H_BACK_PORCH(3), .V_FRONT_PORCH(2),
    .V_BACK_PORCH(3), .VIDEO_WIDTH(4)
  ) dut_s (
    .clock(clock), .reset(reset), .in_Hsync(in_hs), .in_Vsync(in_vs),
    .in_Red(in_r), .in_Green(in_g), .in_Blue(in_b),
    .out_Hsync(s_hs), .out_Vsync(s_vs), .out_Red(s_r), .out_Green(s_g),
    .out_Blue(s_b), .out_locked(s_lk), .out_resync(s_rs));

  wire [15:0] d_out = {d_hs, d_vs, d_r, d_g, d_b, d_lk, d_rs};
  wire [15:0] s_out = {s_hs, s_vs, s_r, s_g, s_b, s_lk, s_rs};

  function automatic logic [15:0] pk(input logic hs, input logic vs,
                                     input logic [3:0] r, input logic [3:0] g,
                                     input logic [3:0] b, input logic lk,
                                     input logic rs);
    return {hs, vs, r, g, b, lk, rs};
  endfunction

  task automatic chk(input string nm, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic drive(input logic vs, input logic hs, input logic [3:0] r,
                       input logic [3:0] g, input logic [3:0] b);
    in_vs = vs; in_hs = hs; in_r = r; in_g = g; in_b = b;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic       vs, hs;
    logic [3:0] r, g, b;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int low, vlow, r, c;
    logic ehs, evs, act;

    tbl[0] = '{1'b0, 1'b0, 4'h1, 4'h2, 4'h3, IDLE};
    tbl[1] = '{1'b1, 1'b1, 4'hF, 4'hA, 4'h5, pk(1, 1, 4'hF, 4'hA, 4'h5, 1, 0)};
    tbl[2] = '{1'b1, 1'b1, 4'h7, 4'h8, 4'h9, pk(1, 1, 4'h7, 4'h8, 4'h9, 1, 0)};
    tbl[3] = '{1'b0, 1'b0, 4'h1, 4'h1, 4'h1, pk(1, 1, 4'h1, 4'h1, 4'h1, 1, 0)};

    // Reset values on both instances.
    reset = 1'b1;
    drive(0, 0, 4'h0, 4'h0, 4'h0);
    tick();
    chk("reset_dflt", d_out, IDLE);
    chk("reset_small", s_out, IDLE);
    reset = 1'b0;

    // With no rising in_Vsync, the block stays unlocked and idle.
    for (int i = 0; i < 100; i++) begin
      drive(0, 1'(i), 4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)),
            4'($urandom_range(1, 15)));
      tick();
      chk("unlocked_idle", d_out, IDLE);
    end

    // Lock sequence: the frame start is at vector 1 (col 0).
    for (int i = 0; i < 4; i++) begin
      drive(tbl[i].vs, tbl[i].hs, tbl[i].r, tbl[i].g, tbl[i].b);
      tick();
      chk($sformatf("vec%0d", i), d_out, tbl[i].exp);
    end

    // Rest of line 0: hsync is low for cols 656..751 and colour is blanked
    // from col 640.
    low = 0;
    for (int cc = 3; cc < 800; cc++) begin
      drive(0, 0, 4'hC, 4'h3, 4'h6);
      tick();
      ehs = !(cc >= 656 && cc <= 751);
      if (cc < 640) chk("line0", d_out, pk(ehs, 1, 4'hC, 4'h3, 4'h6, 1, 0));
      else          chk("line0", d_out, pk(ehs, 1, 4'h0, 4'h0, 4'h0, 1, 0));
      if (!d_hs) low++;
    end
    chk("hsync_low_cycles", 16'(low), 16'd96);

    // Small raster: two frames from an aligned upstream.
    reset = 1'b1;
    drive(0, 0, 4'h0, 4'h0, 4'h0);
    tick();
    chk("small_reset2", s_out, IDLE);
    reset = 1'b0;
    vlow = 0;
    for (int n = 0; n < 600; n++) begin
      r = (n / 20) % 15;
      c = n % 20;
      drive(r < 8, c < 12, 4'hF, 4'(c), 4'(r));
      tick();
      ehs = !(c >= 14 && c <= 16);
      evs = !(r >= 10 && r <= 11);
      act = (c < 12) && (r < 8);
      if (act) chk("frame", s_out, pk(ehs, evs, 4'hF, 4'(c), 4'(r), 1, 0));
      else     chk("frame", s_out, pk(ehs, evs, 4'h0, 4'h0, 4'h0, 1, 0));
      if (!s_vs) vlow++;
    end
    chk("vsync_low_cycles", 16'(vlow), 16'd80);

    // Third frame: aligned up to (4,4). in_Vsync drops at (4,4) and rises
    // at (5,4), which injects a frame start away from the origin.
    for (int n = 0; n < 85; n++) begin
      c = n % 20;
      drive(n != 84, c < 12, 4'h1, 4'h1, 4'h1);
      tick();
      chk("pre_resync", {14'd0, s_lk, s_rs}, 16'd2);
    end
    drive(1, 1, 4'h9, 4'h6, 4'h3);
    tick();
    chk("resync_pulse", s_out, pk(1, 1, 4'h9, 4'h6, 4'h3, 1, 1));
    // The following outputs must walk cols 1.. of row 0.
    for (int k = 1; k < 20; k++) begin
      drive(1, 1, 4'(k), 4'h5, 4'h5);
      tick();
      ehs = !(k >= 14 && k <= 16);
      if (k < 12) chk("post_resync", s_out, pk(ehs, 1, 4'(k), 4'h5, 4'h5, 1, 0));
      else        chk("post_resync", s_out, pk(ehs, 1, 4'h0, 4'h0, 4'h0, 1, 0));
    end

    // Run to (15,11), which lies inside both sync pulses, then reset for
    // one cycle. A rising in_Vsync during that reset cycle must not lock.
    for (int n = 0; n < 215; n++) begin
      drive(0, 0, 4'hA, 4'hA, 4'hA);
      tick();
    end
    drive(0, 0, 4'hA, 4'hA, 4'hA);
    tick();
    chk("pre_reset_pulses", s_out, pk(0, 0, 4'h0, 4'h0, 4'h0, 1, 0));
    reset = 1'b1;
    drive(1, 1, 4'hF, 4'hF, 4'hF);
    tick();
    chk("reset_mid_frame", s_out, IDLE);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      drive(0, 0, 4'hF, 4'hF, 4'hF);
      tick();
      chk("post_reset_idle", s_out, IDLE);
    end
    drive(1, 1, 4'h2, 4'h4, 4'h8);
    tick();
    chk("relock", s_out, pk(1, 1, 4'h2, 4'h4, 4'h8, 1, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
